spi_pico_deframer: RTL and testbench

Upstream stage of the SPI peripheral. It oversamples the external sclk/serial_in pair on the internal clock and deframes the bitstream: the first byte after idle is the register address, and each following byte is write data with an auto-incrementing address. It drives write_data, mux_control_signal and msg_flag to the write-latch/readout logic. It also drives sclk_stop_rstn, which that logic ANDs with rstn when sclk goes idle.

---
 rtl/spi_pico_deframer_pkg.sv | 13 +
 rtl/spi_pico_deframer_if.sv | 23 ++
 rtl/spi_pico_deframer_sync_edge.sv | 33 +++
 rtl/spi_pico_deframer.sv | 116 +++++++++++
 tb/tb_spi_pico_deframer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pico_deframer_pkg.sv
// Shared types and widths for the SPI deframer slice.
package spi_pico_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 8;

endpackage

// File: rtl/spi_pico_deframer_if.sv
// Pin-level bundle of the deframer: SPI inputs plus the write-latch side outputs.
interface spi_pico_deframer_if;
    import spi_pico_pkg::*;

    logic              sclk;
    logic              serial_in;
    logic [BYTE_W-1:0] write_data;
    logic [ADDR_W-1:0] mux_control_signal;
    logic              msg_flag;
    logic              sclk_stop_rstn;
    logic              frame_active;

    modport master (
        output sclk, serial_in,
        input  write_data, mux_control_signal, msg_flag, sclk_stop_rstn, frame_active
    );

    modport slave (
        input  sclk, serial_in,
        output write_data, mux_control_signal, msg_flag, sclk_stop_rstn, frame_active
    );

endinterface

// File: rtl/spi_pico_deframer_sync_edge.sv
// Input synchronisers for sclk/serial_in and sclk rising-edge detection.
module pico_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic iclk,
    input  logic rstn,
    input  logic i_sclk,
    input  logic i_serial_in,
    output logic o_sclk_rise,
    output logic o_serial_bit
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sin_sync;
    logic                   r_sclk_prev;

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            r_sclk_sync <= '0;
            r_sin_sync  <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_sin_sync  <= {r_sin_sync[SYNC_STAGES-2:0], i_serial_in};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    // Equal-depth chains keep the data bit aligned with the detected edge.
    assign o_sclk_rise  = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
    assign o_serial_bit = r_sin_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_pico_deframer.sv
// Deframes an oversampled SPI stream: address byte, then auto-incrementing write bytes.
module spi_pico_deframer
    import spi_pico_pkg::*;
#(
    parameter int IDLE_CYCLES = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic              iclk,
    input  logic              rstn,
    input  logic              sclk,
    input  logic              serial_in,
    output logic [BYTE_W-1:0] write_data,
    output logic [ADDR_W-1:0] mux_control_signal,
    output logic              msg_flag,
    output logic              sclk_stop_rstn,
    output logic              frame_active
);

    localparam int IDLE_W = $clog2(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);

    logic              w_rise;
    logic              w_bit;
    logic [BYTE_W-1:0] w_byte;

    state_t            r_state;
    logic [BYTE_W-2:0] r_shreg;
    logic [2:0]        r_bit_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [ADDR_W-1:0] r_addr_ptr;
    logic              r_first_data;
    logic [BYTE_W-1:0] r_write_data;
    logic [ADDR_W-1:0] r_mux_ctrl;
    logic              r_msg_flag;
    logic              r_stop_rstn;
    logic              r_frame_active;

    pico_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .iclk         (iclk),
        .rstn         (rstn),
        .i_sclk       (sclk),
        .i_serial_in  (serial_in),
        .o_sclk_rise  (w_rise),
        .o_serial_bit (w_bit)
    );

    assign w_byte = {r_shreg, w_bit};

    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= S_IDLE;
            r_shreg        <= '0;
            r_bit_cnt      <= '0;
            r_idle_cnt     <= '0;
            r_addr_ptr     <= '0;
            r_first_data   <= 1'b0;
            r_write_data   <= '0;
            r_mux_ctrl     <= '0;
            r_msg_flag     <= 1'b0;
            r_stop_rstn    <= 1'b0;
            r_frame_active <= 1'b0;
        end else begin
            r_msg_flag <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_rise) begin
                    r_state        <= S_ADDR;
                    r_stop_rstn    <= 1'b1;
                    r_frame_active <= 1'b1;
                    r_shreg        <= w_byte[BYTE_W-2:0];
                    r_bit_cnt      <= 3'd1;
                    r_idle_cnt     <= '0;
                end
            end else if (w_rise) begin
                // An edge in the timeout cycle keeps the frame alive.
                r_idle_cnt <= '0;
                r_shreg    <= w_byte[BYTE_W-2:0];
                r_bit_cnt  <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    if (r_state == S_ADDR) begin
                        r_addr_ptr   <= w_byte;
                        r_first_data <= 1'b1;
                        r_state      <= S_DATA;
                    end else begin
                        r_write_data <= w_byte;
                        r_msg_flag   <= 1'b1;
                        if (r_first_data) begin
                            r_mux_ctrl   <= r_addr_ptr;
                            r_first_data <= 1'b0;
                        end else begin
                            r_addr_ptr <= r_addr_ptr + 8'd1;
                            r_mux_ctrl <= r_addr_ptr + 8'd1;
                        end
                    end
                end
            end else if (r_idle_cnt == IDLE_LAST) begin
                r_state        <= S_IDLE;
                r_stop_rstn    <= 1'b0;
                r_frame_active <= 1'b0;
                r_bit_cnt      <= '0;
                r_first_data   <= 1'b0;
                r_idle_cnt     <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign write_data         = r_write_data;
    assign mux_control_signal = r_mux_ctrl;
    assign msg_flag           = r_msg_flag;
    assign sclk_stop_rstn     = r_stop_rstn;
    assign frame_active       = r_frame_active;

endmodule

// File: tb/tb_spi_pico_deframer.sv
// Self-checking bench: table-driven frames with a scoreboard of expected write events.
`timescale 1ns/1ps
module tb_spi_pico_deframer;

    localparam int IDLE = 64;
    localparam int SYNC = 2;

    typedef struct {
        int              half;
        logic [7:0]      addr;
        int              nd;
        logic [2:0][7:0] d;
    } vec_t;

    typedef struct {
        logic [7:0] mux;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic iclk = 1'b0;
    logic rstn;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_rise_cyc = 0;
    logic [7:0] last_mux = '0;
    logic [7:0] last_data = '0;
    exp_t sb[$];
    vec_t vecs[9];

    spi_pico_deframer_if bus ();

    spi_pico_deframer #(
        .IDLE_CYCLES (IDLE),
        .SYNC_STAGES (SYNC)
    ) dut (
        .iclk               (iclk),
        .rstn               (rstn),
        .sclk               (bus.sclk),
        .serial_in          (bus.serial_in),
        .write_data         (bus.write_data),
        .mux_control_signal (bus.mux_control_signal),
        .msg_flag           (bus.msg_flag),
        .sclk_stop_rstn     (bus.sclk_stop_rstn),
        .frame_active       (bus.frame_active)
    );

    always #5 iclk = ~iclk;
    always @(posedge iclk) cyc <= cyc + 1;

    // Scoreboard consumer: every msg_flag pulse must match the oldest expectation.
    always @(negedge iclk) begin
        if (bus.msg_flag) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL msg_unexpected: got mux=%02h data=%02h at cyc %0d, required no pulse",
                         bus.mux_control_signal, bus.write_data, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.mux_control_signal !== e.mux || bus.write_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL msg_event: got mux=%02h data=%02h cyc=%0d, required mux=%02h data=%02h cyc=%0d",
                             bus.mux_control_signal, bus.write_data, cyc, e.mux, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, required %02h", name, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int lo, input int hi,
                            input logic push, input logic [7:0] m, input logic [7:0] d);
        exp_t e;
        bus.sclk      = 1'b0;
        bus.serial_in = b;
        #(lo * 10);
        bus.sclk      = 1'b1;
        last_rise_cyc = cyc;
        if (push) begin
            e.mux  = m;
            e.data = d;
            e.cyc  = cyc + SYNC + 1;
            sb.push_back(e);
            last_mux  = m;
            last_data = d;
        end
        #(hi * 10);
    endtask

    task automatic send_byte(input logic [7:0] v, input int half, input logic push,
                             input logic [7:0] m, input int gap_bit, input int gap_lo);
        for (int i = 7; i >= 0; i--)
            send_bit(v[i], (i == gap_bit) ? gap_lo : half, half, push && (i == 0), m, v);
    endtask

    task automatic align_phase();
        @(posedge iclk);
        #($urandom_range(1, 9));
    endtask

    task automatic send_frame(input vec_t v);
        align_phase();
        send_byte(v.addr, v.half, 1'b0, 8'h00, -1, 0);
        for (int j = 0; j < v.nd; j++)
            send_byte(v.d[j], v.half, 1'b1, v.addr + 8'(j), -1, 0);
        bus.sclk = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.sclk_stop_rstn && n < 300) begin
            @(posedge iclk);
            #1;
            n++;
        end
        checks++;
        if (bus.sclk_stop_rstn) begin
            errors++;
            $display("FAIL %s_timeout: sclk_stop_rstn still 1 after %0d cycles, required 0", tag, n);
        end else if (cyc - last_rise_cyc != IDLE + SYNC + 1) begin
            errors++;
            $display("FAIL %s_idle_delay: got %0d cycles, required %0d", tag,
                     cyc - last_rise_cyc, IDLE + SYNC + 1);
        end
        chk({tag, "_frame_active"}, {7'd0, bus.frame_active}, 8'h00);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d missing pulses, required 0", tag, sb.size());
            sb.delete();
        end
        chk({tag, "_hold_mux"}, bus.mux_control_signal, last_mux);
        chk({tag, "_hold_data"}, bus.write_data, last_data);
    endtask

    initial begin
        vecs[0] = '{half: 4, addr: 8'h02, nd: 1, d: {8'h00, 8'h00, 8'hA5}};
        vecs[1] = '{half: 4, addr: 8'h3D, nd: 3, d: {8'h33, 8'h22, 8'h11}};
        vecs[2] = '{half: 5, addr: 8'hFF, nd: 2, d: {8'h00, 8'h02, 8'h01}};
        for (int k = 3; k < 9; k++) begin
            vecs[k].half = SYNC + 1 + (k - 3);
            vecs[k].addr = 8'($urandom);
            vecs[k].nd   = 2;
            vecs[k].d    = 24'($urandom);
        end

        rstn          = 1'b0;
        bus.sclk      = 1'b0;
        bus.serial_in = 1'b0;
        repeat (5) @(posedge iclk);
        #1;
        chk("rst_write_data", bus.write_data, 8'h00);
        chk("rst_mux", bus.mux_control_signal, 8'h00);
        chk("rst_msg_flag", {7'd0, bus.msg_flag}, 8'h00);
        chk("rst_stop_rstn", {7'd0, bus.sclk_stop_rstn}, 8'h00);
        chk("rst_frame_active", {7'd0, bus.frame_active}, 8'h00);
        @(negedge iclk);
        rstn = 1'b1;
        repeat (3) @(posedge iclk);

        for (int k = 0; k < 9; k++) begin
            send_frame(vecs[k]);
            wait_idle($sformatf("vec%0d", k));
        end

        // Bit-to-bit gap of exactly IDLE cycles: edge wins, byte completes.
        align_phase();
        send_byte(8'h10, 4, 1'b0, 8'h00, -1, 0);
        #1 chk("gap_active", {7'd0, bus.frame_active}, 8'h01);
        send_byte(8'h5A, 4, 1'b1, 8'h10, 3, IDLE - 4);
        bus.sclk = 1'b0;
        wait_idle("gap64");

        // One cycle longer: frame times out before bit 0, so no write.
        align_phase();
        send_byte(8'h20, 4, 1'b0, 8'h00, -1, 0);
        send_byte(8'h66, 4, 1'b0, 8'h00, 0, IDLE + 1 - 4);
        bus.sclk = 1'b0;
        wait_idle("gap65");

        // Address only, then partial data byte: neither changes the outputs.
        align_phase();
        send_byte(8'h55, 4, 1'b0, 8'h00, -1, 0);
        bus.sclk = 1'b0;
        wait_idle("addr_only");
        align_phase();
        send_byte(8'h01, 4, 1'b0, 8'h00, -1, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 4, 4, 1'b0, 8'h00, 8'h00);
        bus.sclk = 1'b0;
        wait_idle("partial");
        send_frame('{half: 4, addr: 8'h03, nd: 1, d: {8'h00, 8'h00, 8'h7E}});
        wait_idle("after_partial");

        // Asynchronous reset in the middle of a data byte.
        align_phase();
        send_byte(8'h01, 4, 1'b0, 8'h00, -1, 0);
        send_bit(1'b1, 4, 4, 1'b0, 8'h00, 8'h00);
        send_bit(1'b0, 4, 4, 1'b0, 8'h00, 8'h00);
        send_bit(1'b1, 4, 2, 1'b0, 8'h00, 8'h00);
        rstn = 1'b0;
        #1;
        chk("mid_rst_write_data", bus.write_data, 8'h00);
        chk("mid_rst_mux", bus.mux_control_signal, 8'h00);
        chk("mid_rst_stop_rstn", {7'd0, bus.sclk_stop_rstn}, 8'h00);
        chk("mid_rst_frame_active", {7'd0, bus.frame_active}, 8'h00);
        bus.sclk = 1'b0;
        last_mux  = 8'h00;
        last_data = 8'h00;
        #50;
        rstn = 1'b1;
        repeat (3) @(posedge iclk);
        send_frame('{half: 4, addr: 8'h01, nd: 1, d: {8'h00, 8'h00, 8'hC3}});
        wait_idle("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
